// File: rtl/updown_event_counter.sv
// Purpose : debounced up/down push-button event counter with parallel load and
//           wrap/saturate limits; feeds the three-digit seven-segment decoder.
// Latency : a press held from edge 0 shows up on o_count from edge DEB_CYCLES+4.
// Backpressure: none; every accepted press is applied on the cycle its pulse fires.
//
// Ports:
//   i_clk        system clock, rising edge
//   i_rst        synchronous active-high reset, highest priority
//   i_btn_up_n   raw active-low up button, asynchronous to i_clk
//   i_btn_dn_n   raw active-low down button, asynchronous to i_clk
//   i_load       level; o_count <= i_load_val and o_ovf cleared while high
//   i_load_val   parallel load value (switches)
//   i_wrap_en    1 = wrap at the limits, 0 = saturate and flag o_ovf
//   o_count      registered count
//   o_at_max     registered, o_count == 2^W-1
//   o_at_min     registered, o_count == 0
//   o_ovf        sticky, attempted step past a limit while saturating
module updown_event_counter #(
  parameter int W          = 8,
  parameter int DEB_CYCLES = 500000
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_btn_up_n,
  input  logic         i_btn_dn_n,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_wrap_en,
  output logic [W-1:0] o_count,
  output logic         o_at_max,
  output logic         o_at_min,
  output logic         o_ovf
);

  localparam int             DCW     = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [DCW-1:0] DC_LAST = DCW'(DEB_CYCLES - 1);
  localparam logic [W-1:0]   CNT_MAX = '1;

  // Index 0 = up button, index 1 = down button.
  logic [1:0]     w_pin;
  logic [1:0]     r_sync1;
  logic [1:0]     r_sync2;
  logic [1:0]     r_st;
  logic [1:0]     r_st_d;
  logic [1:0]     r_ev;
  logic [DCW-1:0] r_dc [2];

  // A button held through reset must be released before it can generate an
  // event. r_arm gets set only once the synchroniser carries real pin data
  // again (r_settle[1]) and both the synchronised and debounced levels say
  // "released".
  logic [1:0]     r_arm;
  logic [1:0]     r_settle;

  assign w_pin = {i_btn_dn_n, i_btn_up_n};

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync1  <= 2'b11;
      r_sync2  <= 2'b11;
      r_st     <= 2'b11;
      r_st_d   <= 2'b11;
      r_ev     <= 2'b00;
      r_arm    <= 2'b00;
      r_settle <= 2'b00;
      for (int b = 0; b < 2; b++) begin
        r_dc[b] <= '0;
      end
    end else begin
      r_sync1  <= w_pin;
      r_sync2  <= r_sync1;
      r_st_d   <= r_st;
      r_settle <= {r_settle[0], 1'b1};
      for (int b = 0; b < 2; b++) begin
        if (r_sync2[b] == r_st[b]) begin
          r_dc[b] <= '0;
        end else if (r_dc[b] == DC_LAST) begin
          r_st[b] <= r_sync2[b];
          r_dc[b] <= '0;
        end else begin
          r_dc[b] <= r_dc[b] + 1'b1;
        end
        if (r_settle[1] && r_sync2[b] && r_st[b]) begin
          r_arm[b] <= 1'b1;
        end
        // One-cycle pulse on the debounced press edge only.
        r_ev[b] <= r_st_d[b] & ~r_st[b] & r_arm[b];
      end
    end
  end

  // Count update: load beats events, simultaneous up+down cancel.
  logic         w_inc;
  logic         w_dec;
  logic [W-1:0] w_cnt_nxt;
  logic         w_ovf_nxt;
  logic [W-1:0] r_count;
  logic         r_at_max;
  logic         r_at_min;
  logic         r_ovf;

  assign w_inc = r_ev[0] & ~r_ev[1];
  assign w_dec = r_ev[1] & ~r_ev[0];

  always_comb begin
    w_cnt_nxt = r_count;
    w_ovf_nxt = r_ovf;
    if (i_load) begin
      w_cnt_nxt = i_load_val;
      w_ovf_nxt = 1'b0;
    end else if (w_inc) begin
      if (r_count == CNT_MAX) begin
        if (i_wrap_en) begin
          w_cnt_nxt = '0;
        end else begin
          w_ovf_nxt = 1'b1;
        end
      end else begin
        w_cnt_nxt = r_count + 1'b1;
      end
    end else if (w_dec) begin
      if (r_count == '0) begin
        if (i_wrap_en) begin
          w_cnt_nxt = CNT_MAX;
        end else begin
          w_ovf_nxt = 1'b1;
        end
      end else begin
        w_cnt_nxt = r_count - 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_count  <= '0;
      r_at_max <= 1'b0;
      r_at_min <= 1'b1;
      r_ovf    <= 1'b0;
    end else begin
      r_count  <= w_cnt_nxt;
      // Flags come from the next value so they move on the same edge as count.
      r_at_max <= (w_cnt_nxt == CNT_MAX);
      r_at_min <= (w_cnt_nxt == '0);
      r_ovf    <= w_ovf_nxt;
    end
  end

  assign o_count  = r_count;
  assign o_at_max = r_at_max;
  assign o_at_min = r_at_min;
  assign o_ovf    = r_ovf;

endmodule

// File: tb/tb_updown_event_counter.sv
// Directed plus randomized bench for updown_event_counter (W=8, DEB_CYCLES=4).
// The reference keeps the count as a plain integer and applies one step per
// accepted press; a press is accepted when the pin stays low >= DEB cycles.
module tb_updown_event_counter;
  localparam int DEB = 4;
  localparam int W   = 8;
  localparam int MAXV = (1 << W) - 1;

  logic         clk = 1'b0;
  logic         rst;
  logic         up_n;
  logic         dn_n;
  logic         load;
  logic [W-1:0] load_val;
  logic         wrap_en;
  logic [W-1:0] count;
  logic         at_max;
  logic         at_min;
  logic         ovf;

  int vectors = 0;
  int errs    = 0;
  int m_cnt   = 0;
  bit m_ovf   = 1'b0;

  always #5 clk = ~clk;

  updown_event_counter #(.W(W), .DEB_CYCLES(DEB)) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_btn_up_n (up_n),
    .i_btn_dn_n (dn_n),
    .i_load     (load),
    .i_load_val (load_val),
    .i_wrap_en  (wrap_en),
    .o_count    (count),
    .o_at_max   (at_max),
    .o_at_min   (at_min),
    .o_ovf      (ovf)
  );

  // Advance n rising edges, then settle 1 time unit past the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, ".count"},  32'(count),  32'(m_cnt));
    check({tag, ".ovf"},    32'(ovf),    32'(m_ovf));
    check({tag, ".at_max"}, 32'(at_max), 32'(m_cnt == MAXV));
    check({tag, ".at_min"}, 32'(at_min), 32'(m_cnt == 0));
  endtask

  // One accepted press applied to the integer reference.
  function automatic void m_step(input bit up, input bit dn);
    if (up && dn) return;
    if (up) begin
      if (m_cnt == MAXV) begin
        if (wrap_en) m_cnt = 0; else m_ovf = 1'b1;
      end else begin
        m_cnt = m_cnt + 1;
      end
    end else if (dn) begin
      if (m_cnt == 0) begin
        if (wrap_en) m_cnt = MAXV; else m_ovf = 1'b1;
      end else begin
        m_cnt = m_cnt - 1;
      end
    end
  endfunction

  // Hold the selected buttons low for len cycles, then release long enough
  // for the debounced level to return to released before anything else.
  task automatic press(input bit up, input bit dn, input int len);
    if (up) up_n = 1'b0;
    if (dn) dn_n = 1'b0;
    tick(len);
    up_n = 1'b1;
    dn_n = 1'b1;
    tick(DEB + 6);
    if (len >= DEB) m_step(up, dn);
  endtask

  task automatic do_load(input int v);
    load_val = W'(v);
    load     = 1'b1;
    tick(1);
    load     = 1'b0;
    m_cnt    = v;
    m_ovf    = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    m_cnt = 0;
    m_ovf = 1'b0;
    tick(5);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int op;
    int v;
    int len;
    rst      = 1'b1;
    up_n     = 1'b1;
    dn_n     = 1'b1;
    load     = 1'b0;
    load_val = '0;
    wrap_en  = 1'b0;
    tick(3);
    check_model("reset");
    rst = 1'b0;
    tick(5);

    // Exact latency: first edge seeing the pin low is edge 0; count is seen
    // as 1 from edge DEB+4, i.e. it flips on edge DEB+3.
    up_n = 1'b0;
    for (int k = 0; k < 20; k++) begin
      tick(1);
      check("latency", 32'(count), (k >= DEB + 3) ? 32'd1 : 32'd0);
    end
    up_n = 1'b1;
    tick(DEB + 6);
    m_cnt = 1;
    check_model("single_press");

    // Pulses shorter than DEB never register.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      up_n = 1'b0;
      tick(3);
      up_n = 1'b1;
      tick(2);
    end
    tick(DEB + 6);
    check_model("glitch");

    // Saturation at the top and sticky ovf.
    wrap_en = 1'b0;
    do_load(254);
    check_model("load254");
    press(1'b1, 1'b0, 10);
    check_model("sat_up1");
    press(1'b1, 1'b0, 10);
    check_model("sat_up2");
    press(1'b1, 1'b0, 10);
    check_model("sat_up3");
    check("ovf_set", 32'(ovf), 32'd1);
    do_load(17);
    check_model("load_clears_ovf");

    // Wrap in both directions.
    do_load(0);
    wrap_en = 1'b1;
    press(1'b0, 1'b1, 10);
    check_model("wrap_dn");
    press(1'b1, 1'b0, 10);
    check_model("wrap_up");

    // Simultaneous presses cancel.
    do_load(100);
    press(1'b1, 1'b1, 10);
    check_model("both");

    // Load on the very edge the up event is applied: load wins.
    up_n     = 1'b0;
    tick(DEB + 3);
    load_val = 8'd200;
    load     = 1'b1;
    tick(1);
    load     = 1'b0;
    m_cnt    = 200;
    m_ovf    = 1'b0;
    check("load_vs_ev", 32'(count), 32'd200);
    tick(10);
    up_n = 1'b1;
    tick(DEB + 6);
    check_model("load_vs_ev_after");

    // Reset mid-debounce with the button still held.
    do_load(77);
    up_n = 1'b0;
    tick(4);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    m_cnt = 0;
    m_ovf = 1'b0;
    check_model("rst_mid");
    tick(20);
    check_model("held_after_rst");
    up_n = 1'b1;
    tick(DEB + 6);
    press(1'b1, 1'b0, 10);
    check_model("repress_after_rst");

    // Randomized operations against the integer reference.
    for (int i = 0; i < 60; i++) begin
      op = $urandom_range(0, 5);
      case (op)
        0: press(1'b1, 1'b0, $urandom_range(DEB, DEB + 8));
        1: press(1'b0, 1'b1, $urandom_range(DEB, DEB + 8));
        2: press(1'b1, 1'b1, $urandom_range(DEB, DEB + 8));
        3: begin
          len = $urandom_range(1, DEB - 1);
          if ($urandom_range(0, 1) == 1) press(1'b1, 1'b0, len);
          else press(1'b0, 1'b1, len);
        end
        4: begin
          case ($urandom_range(0, 4))
            0: v = 0;
            1: v = 1;
            2: v = MAXV - 1;
            3: v = MAXV;
            default: v = $urandom_range(0, MAXV);
          endcase
          do_load(v);
        end
        default: begin
          wrap_en = 1'($urandom_range(0, 1));
          tick(1);
        end
      endcase
      check_model("random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
